// File: rtl/echo_pkg.sv
// Shared types, default widths and saturating arithmetic for the echo datapath.
// Latency: combinational helpers only; no state.
// Backpressure: n/a (pure functions and types).
package echo_pkg;

    localparam int DATA_W     = 16;
    localparam int GAIN_W     = 16;
    localparam int DEF_ADDR_W = 15;
    localparam int PROD_W     = DATA_W + GAIN_W;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [GAIN_W-1:0] gain_t;

    localparam sample_t SMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam sample_t SMIN = {1'b1, {(DATA_W-1){1'b0}}};

    // Add two samples one bit wider, then clamp to the sample range.
    function automatic sample_t sat_add(sample_t a, sample_t b);
        logic signed [DATA_W:0] s;
        s = (DATA_W+1)'(a) + (DATA_W+1)'(b);
        if (s[DATA_W] != s[DATA_W-1]) begin
            return s[DATA_W] ? SMIN : SMAX;
        end
        return s[DATA_W-1:0];
    endfunction

    // Full-width signed product scaled by Q1.15 with an arithmetic shift,
    // then clamped. Only full-scale negative times full-scale negative
    // can leave the range, and it lands on SMAX.
    function automatic sample_t sat_q15_mul(sample_t a, gain_t g);
        logic signed [PROD_W-1:0] p;
        logic [GAIN_W:0]          hi;
        p  = PROD_W'(a) * PROD_W'(g);
        p  = p >>> (GAIN_W - 1);
        hi = p[PROD_W-1:DATA_W-1];
        if ((hi != '0) && (hi != '1)) begin
            return p[PROD_W-1] ? SMIN : SMAX;
        end
        return p[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/echo_datapath_if.sv
// Sample, gain, delay and FSM strobe bundle between fsm_echo and the datapath.
// Latency: wires only.
// Backpressure: none here; the FSM strobes carry all flow control.
interface echo_datapath_if;
    import echo_pkg::*;

    sample_t     pi_data;
    gain_t       pi_gain;
    logic [15:0] pi_feedback_delay;
    logic        pi_clk_en_s0;
    logic        pi_clk_en_s1;
    logic        pi_we_en;
    logic        pi_rd_en;
    logic        pi_mux_sel;
    sample_t     po_data;

    modport master (
        output pi_data, pi_gain, pi_feedback_delay,
        output pi_clk_en_s0, pi_clk_en_s1, pi_we_en, pi_rd_en, pi_mux_sel,
        input  po_data
    );

    modport slave (
        input  pi_data, pi_gain, pi_feedback_delay,
        input  pi_clk_en_s0, pi_clk_en_s1, pi_we_en, pi_rd_en, pi_mux_sel,
        output po_data
    );

endinterface

// File: rtl/echo_delay_ram.sv
// Simple dual-port delay memory: one write port, one registered read port.
// Latency: read data valid one cycle after a pi_rd_en edge.
// Backpressure: none; read register holds while pi_rd_en is low.
module echo_delay_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15
) (
    input  logic              pi_clk,
    input  logic              pi_sreset,
    input  logic              pi_we,
    input  logic [ADDR_W-1:0] pi_wr_addr,
    input  logic [DATA_W-1:0] pi_wr_data,
    input  logic              pi_rd_en,
    input  logic [ADDR_W-1:0] pi_rd_addr,
    output logic [DATA_W-1:0] po_rd_data
);

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    // Write port; contents are never cleared so this maps onto block RAM.
    always_ff @(posedge pi_clk) begin
        if (pi_we) begin
            mem[pi_wr_addr] <= pi_wr_data;
        end
    end

    // Registered read port with output-register reset.
    always_ff @(posedge pi_clk) begin
        if (pi_sreset) begin
            po_rd_data <= '0;
        end else if (pi_rd_en) begin
            po_rd_data <= mem[pi_rd_addr];
        end
    end

endmodule

// File: rtl/echo_datapath.sv
// Feedback echo y[n] = x[n] + g*y[n-D]: s0/s1 pipeline, delay RAM, Q1.15 gain, saturating sum.
// Latency: one s0 enable plus one s1 enable from pi_data to po_data (2 cycles back-to-back).
// Backpressure: all state holds while every strobe is low; po_data is registered and stable.
module echo_datapath
    import echo_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic           pi_clk,
    input  logic           pi_sreset,
    echo_datapath_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    sample_t           x_s0;
    sample_t           y_s1;
    sample_t           rd_q;
    sample_t           echo;
    sample_t           sum;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] d_eff;
    logic [ADDR_W-1:0] rd_addr;
    logic              mem_we;

    // Clamp the requested delay to 1..DEPTH-1 so the read never aliases the write slot.
    always_comb begin
        d_eff = ADDR_W'(bus.pi_feedback_delay);
        if (bus.pi_feedback_delay == '0) begin
            d_eff = ADDR_W'(1);
        end else if (int'(bus.pi_feedback_delay) > DEPTH - 1) begin
            d_eff = ADDR_W'(DEPTH - 1);
        end
    end

    // Read address trails the write pointer by D_eff, wrapping modulo DEPTH.
    always_comb begin
        rd_addr = wr_ptr - d_eff;
    end

    // Echo term and output sum; the dry path forces the echo to zero.
    always_comb begin
        echo = '0;
        if (bus.pi_mux_sel) begin
            echo = sat_q15_mul(rd_q, bus.pi_gain);
        end
        sum = sat_add(x_s0, echo);
    end

    // Reset also blocks the memory write so nothing lands while the pointer clears.
    assign mem_we = bus.pi_we_en && !pi_sreset;

    echo_delay_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .pi_clk     (pi_clk),
        .pi_sreset  (pi_sreset),
        .pi_we      (mem_we),
        .pi_wr_addr (wr_ptr),
        .pi_wr_data (sum),
        .pi_rd_en   (bus.pi_rd_en),
        .pi_rd_addr (rd_addr),
        .po_rd_data (rd_q)
    );

    // Stage s0 captures the incoming sample.
    always_ff @(posedge pi_clk) begin
        if (pi_sreset) begin
            x_s0 <= '0;
        end else if (bus.pi_clk_en_s0) begin
            x_s0 <= bus.pi_data;
        end
    end

    // Stage s1 captures the saturated sum that drives the output.
    always_ff @(posedge pi_clk) begin
        if (pi_sreset) begin
            y_s1 <= '0;
        end else if (bus.pi_clk_en_s1) begin
            y_s1 <= sum;
        end
    end

    // Write pointer advances once per stored sample and wraps naturally.
    always_ff @(posedge pi_clk) begin
        if (pi_sreset) begin
            wr_ptr <= '0;
        end else if (bus.pi_we_en) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
        end
    end

    assign bus.po_data = y_s1;

endmodule

// File: tb/tb_echo_datapath.sv
// Directed bench for echo_datapath: full-depth instance plus a 16-entry instance for wrap/clamp.
// Latency: each sample is an s0+rd edge followed by an s1+we edge.
// Backpressure: stall exercised by dropping every strobe.
module tb_echo_datapath;
    import echo_pkg::*;

    logic pi_clk = 1'b0;
    always #5 pi_clk = ~pi_clk;

    logic        rst_a;
    logic        rst_b;
    sample_t     d_data;
    gain_t       d_gain;
    logic [15:0] d_delay;
    logic        d_s0;
    logic        d_s1;
    logic        d_we;
    logic        d_rd;
    logic        d_mux;

    int checks   = 0;
    int failures = 0;

    echo_datapath_if bus_a ();
    echo_datapath_if bus_b ();

    assign bus_a.pi_data           = d_data;
    assign bus_a.pi_gain           = d_gain;
    assign bus_a.pi_feedback_delay = d_delay;
    assign bus_a.pi_clk_en_s0      = d_s0;
    assign bus_a.pi_clk_en_s1      = d_s1;
    assign bus_a.pi_we_en          = d_we;
    assign bus_a.pi_rd_en          = d_rd;
    assign bus_a.pi_mux_sel        = d_mux;

    assign bus_b.pi_data           = d_data;
    assign bus_b.pi_gain           = d_gain;
    assign bus_b.pi_feedback_delay = d_delay;
    assign bus_b.pi_clk_en_s0      = d_s0;
    assign bus_b.pi_clk_en_s1      = d_s1;
    assign bus_b.pi_we_en          = d_we;
    assign bus_b.pi_rd_en          = d_rd;
    assign bus_b.pi_mux_sel        = d_mux;

    echo_datapath #(.ADDR_W(15)) dut_a (
        .pi_clk    (pi_clk),
        .pi_sreset (rst_a),
        .bus       (bus_a)
    );

    echo_datapath #(.ADDR_W(4)) dut_b (
        .pi_clk    (pi_clk),
        .pi_sreset (rst_b),
        .bus       (bus_b)
    );

    int imp_exp [9] = '{16000, 0, 0, 0, 8000, 0, 0, 0, 4000};

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pi_clk);
        #1;
    endtask

    task automatic idle();
        d_s0 = 1'b0;
        d_s1 = 1'b0;
        d_we = 1'b0;
        d_rd = 1'b0;
    endtask

    // One sample the way fsm_echo sequences it: capture+read, then sum+write.
    task automatic sample(input int x, input bit mux);
        d_data = 16'(x);
        d_mux  = mux;
        d_s0 = 1'b1; d_rd = 1'b1; d_s1 = 1'b0; d_we = 1'b0;
        tick();
        d_s0 = 1'b0; d_rd = 1'b0; d_s1 = 1'b1; d_we = 1'b1;
        tick();
        idle();
    endtask

    function automatic int sat16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic reset_a();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
    endtask

    // Reference recurrence on the 16-entry instance.
    task automatic run_golden(input int dly, input int deff, input int g, input int seed);
        int ym [40];
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        chk($sformatf("b_reset_d%0d", dly), int'(bus_b.po_data), 0);
        d_delay = 16'(dly);
        d_gain  = 16'(g);
        for (int n = 0; n < 40; n++) begin
            int x;
            int e;
            bit m;
            x = ((n * 12345 + seed * 777) % 40001) - 20000;
            m = (n >= deff);
            e = x;
            if (m) e = x + sat16((ym[n - deff] * g) >>> 15);
            ym[n] = sat16(e);
            sample(x, m);
            chk($sformatf("wrap_d%0d_n%0d", dly, n), int'(bus_b.po_data), ym[n]);
        end
    endtask

    initial begin
        idle();
        d_data  = '0;
        d_gain  = '0;
        d_delay = 16'd1;
        d_mux   = 1'b0;
        rst_a   = 1'b1;
        rst_b   = 1'b1;

        // Reset held for three cycles under random traffic.
        for (int i = 0; i < 3; i++) begin
            d_data  = 16'($urandom);
            d_gain  = 16'($urandom);
            d_delay = 16'($urandom);
            d_s0 = 1'($urandom); d_s1 = 1'($urandom);
            d_we = 1'($urandom); d_rd = 1'($urandom);
            d_mux = 1'($urandom);
            tick();
        end
        idle();
        d_mux = 1'b0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        chk("reset_po", int'(bus_a.po_data), 0);
        chk("reset_wr_ptr", int'(dut_a.wr_ptr), 0);
        tick();
        chk("reset_po_hold", int'(bus_a.po_data), 0);

        // Dry path: s0 edge then s1+we edge.
        d_delay = 16'd4;
        d_gain  = 16'h4000;
        d_data  = 16'sd1000;
        d_s0 = 1'b1; d_rd = 1'b1;
        tick();
        chk("dry_after_s0", int'(bus_a.po_data), 0);
        d_s0 = 1'b0; d_rd = 1'b0; d_s1 = 1'b1; d_we = 1'b1;
        tick();
        idle();
        chk("dry_po", int'(bus_a.po_data), 1000);
        chk("dry_mem0", int'($signed(dut_a.u_ram.mem[0])), 1000);
        chk("dry_wr_ptr", int'(dut_a.wr_ptr), 1);

        // Echo impulse, D=4, gain 0.5.
        reset_a();
        d_delay = 16'd4;
        d_gain  = 16'h4000;
        for (int n = 0; n < 9; n++) begin
            sample((n == 0) ? 16000 : 0, n >= 4);
            chk($sformatf("impulse_n%0d", n), int'(bus_a.po_data), imp_exp[n]);
        end

        // Positive saturation: 30000 + 30000*0x7FFF.
        reset_a();
        d_delay = 16'd1;
        d_gain  = 16'h7FFF;
        sample(30000, 1'b0);
        chk("satp_seed", int'(bus_a.po_data), 30000);
        sample(30000, 1'b1);
        chk("satp_sum", int'(bus_a.po_data), 32767);

        // Negative corner: echo saturates to +32767, sum is -1.
        reset_a();
        d_gain = 16'h8000;
        sample(-32768, 1'b0);
        chk("satn_seed", int'(bus_a.po_data), -32768);
        sample(-32768, 1'b1);
        chk("satn_sum", int'(bus_a.po_data), -1);

        // Stall: every strobe low, data and mux wiggling.
        for (int i = 0; i < 5; i++) begin
            d_data = 16'(i * 1111 + 7);
            d_mux  = i[0];
            tick();
            chk($sformatf("stall_po_%0d", i), int'(bus_a.po_data), -1);
        end
        chk("stall_wr_ptr", int'(dut_a.wr_ptr), 2);

        // Mid-stream reset with every enable asserted: reset wins.
        d_s0 = 1'b1; d_s1 = 1'b1; d_we = 1'b1; d_rd = 1'b1; d_mux = 1'b1;
        d_data = 16'sd5000;
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        idle();
        chk("midrst_po", int'(bus_a.po_data), 0);
        chk("midrst_wr_ptr", int'(dut_a.wr_ptr), 0);
        d_gain = 16'h7FFF;
        sample(123, 1'b0);
        chk("midrst_dry", int'(bus_a.po_data), 123);
        sample(100, 1'b1);
        chk("midrst_echo_back", int'(bus_a.po_data), 222);

        // Wrap and clamp on the 16-entry instance.
        run_golden(3, 3, 24576, 1);
        chk("wrap_wr_ptr", int'(dut_b.wr_ptr), 8);
        run_golden(0, 1, 24576, 2);
        run_golden(20, 15, -20480, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/echo_datapath.md
Name: echo_datapath

Overview:
Sample datapath controlled by fsm_echo. It implements the feedback echo y[n] = x[n] + g*y[n-D] on a 16-bit signed audio stream.
It holds the circular delay memory, the two-stage s0/s1 pipeline, the gain multiplier and the saturating adder.
All sequencing comes from the FSM strobes (clk_en_s0/s1, we_en, rd_en, mux_sel). This block takes no handshake decisions of its own.

Parameters:
DATA_W, 16, sample width, signed two's complement
GAIN_W, 16, feedback gain width, signed Q1.15
ADDR_W, 15, delay memory address width; DEPTH = 2**ADDR_W samples

Ports:
pi_clk  in  1  clock
pi_sreset  in  1  synchronous active-high reset; top level drives it as system reset OR fsm_echo po_sreset
pi_data  in  DATA_W  input sample (AXI-Stream tdata)
pi_gain  in  GAIN_W  feedback gain, Q1.15
pi_feedback_delay  in  16  echo delay D in samples
pi_clk_en_s0  in  1  capture enable, stage s0
pi_clk_en_s1  in  1  capture enable, stage s1
pi_we_en  in  1  delay memory write strobe
pi_rd_en  in  1  delay memory read strobe
pi_mux_sel  in  1  1 = add echo term, 0 = dry pass-through
po_data  out  DATA_W  output sample (AXI-Stream tdata)

Behaviour:
- Reset (pi_sreset=1 at posedge): x_s0, y_s1, rd_q, wr_ptr all cleared to 0, so po_data=0 the following cycle.
  - Memory contents are not cleared. Stale data is harmless because fsm_echo holds mux_sel=0 until D samples have been written.
  - Reset wins over every enable in the same cycle.
- Stage s0: x_s0 <= pi_data on the clk_en_s0 edge. Held otherwise.
- Delay read:
  - D_eff = clamp(pi_feedback_delay, 1, DEPTH-1).
  - rd_addr = (wr_ptr - D_eff) mod DEPTH.
  - Synchronous read: on a pi_rd_en edge, rd_q <= mem[rd_addr]. rd_q holds when rd_en=0.
- Echo term:
  - prod = signed(rd_q) * signed(pi_gain), full 2*DATA_W bits.
  - echo = sat_DATA_W(prod >>> 15), arithmetic shift.
  - Only -32768 * 0x8000 overflows; it saturates to +32767.
  - echo forced to 0 when pi_mux_sel=0.
- Sum: sum = sat_DATA_W(x_s0 + echo), computed in DATA_W+1 bits and clamped to [-2**(DATA_W-1), 2**(DATA_W-1)-1].
- Stage s1: y_s1 <= sum on the clk_en_s1 edge. po_data = y_s1 (registered, no combinational path from inputs).
- Write: on a pi_we_en edge, mem[wr_ptr] <= sum (the same value s1 captures that edge), then wr_ptr <= wr_ptr+1.
  - wr_ptr wraps from DEPTH-1 to 0.
  - pi_we_en without pi_clk_en_s1 is legal; it writes sum, and y_s1 holds.
- Collisions: D_eff >= 1 guarantees rd_addr != wr_ptr, so read-during-write never hits the same address. No bypass is required.
- Latency: pi_data reaches po_data after one s0 enable plus one s1 enable. That is 2 cycles when both enables are continuous.
- Stall: all enables low means every register and the memory hold. po_data stays stable while downstream ready is low.
- Delay change mid-stream: takes effect on the next read. No flush.
- D_eff handling: pi_feedback_delay >= DEPTH clamps to DEPTH-1; 0 clamps to 1.

Decomposition:
- echo_pkg holds:
  - DATA_W, GAIN_W, ADDR_W defaults;
  - typedef sample_t (logic signed [DATA_W-1:0]);
  - typedef gain_t;
  - function sat_add(sample_t, sample_t) -> sample_t;
  - function sat_q15_mul(sample_t, gain_t) -> sample_t.
- One sub-module: echo_delay_ram. It is a simple dual-port RAM (one write port, one registered read port, same clock) written to infer block RAM, parameterised by DATA_W and ADDR_W.
- Pointers, clamp, multiply and pipeline registers live in echo_datapath.

Test Plan:
- Reset: drive random inputs with pi_sreset=1 for 3 cycles, then deassert -> po_data=0, first write lands at address 0 (checked via hierarchical read).
- Dry path: mux_sel=0, pi_data=1000, s0 then s1 enables on consecutive cycles -> po_data=1000 on the 2nd edge; mem[0]=1000 when we_en accompanies s1.
- Echo impulse: D=4, gain=0x4000, input 16000 then zeros, continuous enables, rd_en/mux_sel driven as fsm_echo drives them -> output sequence 16000,0,0,0,8000,0,0,0,4000.
- Saturation, positive: x=30000, rd_q=30000, gain=0x7FFF -> po_data=32767.
- Saturation, negative: x=-32768, rd_q=-32768, gain=0x8000 -> echo=32767, sum=-1.
- Wrap and clamp: ADDR_W=4, D=3, 40 samples -> matches golden model across pointer wrap. D=0 behaves as D=1; D=20 behaves as D=15.
- Stall and mid-stream reset: hold all enables low for 5 cycles with changing pi_data -> po_data and wr_ptr unchanged. Assert pi_sreset mid-stream -> po_data=0 next cycle, wr_ptr=0, echo absent until mux_sel returns.
